// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: controller state encoding, bubble control value
// and the register-match helper used by hazard detection.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } pipe_state_e;

  // control_wb value carried by a bubble entering MEM/WB
  localparam logic [1:0] CTRL_WB_BUBBLE = 2'b00;

  // $0 is hard-wired to zero, so it never creates a dependency
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] dst,
                                     input logic [REG_ADDR_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check between the load in EX and the
// source operands of the instruction in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  load_use
);

  always_comb begin
    load_use = ex_memread && (reg_match(ex_rt, id_rs) || reg_match(ex_rt, id_rt));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory-wait freeze, taken-branch flush and
// load-use stall, with a sticky memory timeout flag and a stall-cycle counter.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  exmem_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_bubble,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  pipe_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              load_use;
  logic              mem_stall;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use   (load_use)
  );

  // Once waiting, only mem_ready releases the freeze.
  always_comb begin
    if (state_q == ST_MEM_WAIT) mem_stall = !mem_ready;
    else                        mem_stall = mem_req && !mem_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_err_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_err_q     <= mem_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN: begin
        if (mem_stall)            state_d = ST_MEM_WAIT;
        else if (ex_branch_taken) state_d = ST_RUN;
        else if (load_use)        state_d = ST_LOAD_STALL;
        else                      state_d = ST_RUN;
      end
      ST_LOAD_STALL: state_d = mem_stall ? ST_MEM_WAIT : ST_RUN;
      ST_MEM_WAIT:   state_d = mem_ready ? ST_RUN : ST_MEM_WAIT;
      default:       state_d = ST_RUN;
    endcase
  end

  // Branch and load-use are only acted on in RUN; the other states emit defaults.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // The wait counter includes the entry cycle, so mem_err rises after
  // MEM_TIMEOUT consecutive frozen cycles.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_stall) begin
      wait_cnt_d = (wait_cnt_q == TIMEOUT_V) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    mem_err_d     = mem_err_q || (mem_stall && (wait_cnt_d == TIMEOUT_V));
    stall_count_d = stall_count_q;
    if (!pc_en && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  assign mem_err     = mem_err_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: load-use, $0, memory wait,
// branch priority, timeout and reset-abort scenarios.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic        pc_en, ifid_en, exmem_en, ifid_flush, idex_flush, memwb_bubble;
  logic        mem_err;
  logic [15:0] stall_count;
  logic [5:0]  ctrl;

  int total = 0;
  int bad   = 0;

  // {pc_en, ifid_en, exmem_en, ifid_flush, idex_flush, memwb_bubble}
  localparam logic [5:0] C_DEF = 6'b111000;
  localparam logic [5:0] C_LU  = 6'b001010;
  localparam logic [5:0] C_MEM = 6'b000001;
  localparam logic [5:0] C_BR  = 6'b111110;

  pipe_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .exmem_en        (exmem_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_bubble    (memwb_bubble),
    .mem_err         (mem_err),
    .stall_count     (stall_count)
  );

  assign ctrl = {pc_en, ifid_en, exmem_en, ifid_flush, idex_flush, memwb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic rd,
                       input logic [4:0] xrt, input logic br, input logic req, input logic rdy);
    id_rs = rs; id_rt = rt; ex_memread = rd; ex_rt = xrt;
    ex_branch_taken = br; mem_req = req; mem_ready = rdy;
    #1;
  endtask

  // one rising edge; returns on the following falling edge
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    step(); step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("rst_ctrl", 32'(ctrl), 32'(C_DEF));
    chk("rst_cnt", 32'(stall_count), 0);
    chk("rst_err", 32'(mem_err), 0);

    // load-use on rs; inputs held through LOAD_STALL must not re-trigger
    drive(5, 0, 1, 5, 0, 0, 1);
    chk("lu_rs", 32'(ctrl), 32'(C_LU));
    step();
    drive(5, 0, 1, 5, 0, 0, 1);
    chk("lu_hold", 32'(ctrl), 32'(C_DEF));
    chk("lu_cnt", 32'(stall_count), 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    chk("lu_after", 32'(ctrl), 32'(C_DEF));
    chk("lu_cnt2", 32'(stall_count), 1);

    // load-use on rt
    drive(3, 7, 1, 7, 0, 0, 1);
    chk("lu_rt", 32'(ctrl), 32'(C_LU));
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    chk("lu_rt_cnt", 32'(stall_count), 2);

    // $0, no match, not a load
    drive(0, 0, 1, 0, 0, 0, 1);
    chk("r0_nohaz", 32'(ctrl), 32'(C_DEF));
    drive(4, 5, 1, 3, 0, 0, 1);
    chk("nomatch", 32'(ctrl), 32'(C_DEF));
    drive(5, 5, 0, 5, 0, 0, 1);
    chk("noload", 32'(ctrl), 32'(C_DEF));
    step();
    chk("r0_cnt", 32'(stall_count), 2);

    // three-cycle memory wait, release on the fourth
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("mw_frozen", 32'(ctrl), 32'(C_MEM));
      step();
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("mw_release", 32'(ctrl), 32'(C_DEF));
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("mw_cnt", 32'(stall_count), 5);
    chk("mw_err", 32'(mem_err), 0);

    // branch beats load-use; next cycle still RUN so the hazard is seen
    drive(5, 0, 1, 5, 1, 0, 1);
    chk("br_lu", 32'(ctrl), 32'(C_BR));
    step();
    drive(5, 0, 1, 5, 0, 0, 1);
    chk("br_nols", 32'(ctrl), 32'(C_LU));
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("br_cnt", 32'(stall_count), 6);

    // memory wait beats branch; release ignores branch
    drive(5, 0, 1, 5, 1, 1, 0);
    chk("mw_over_br", 32'(ctrl), 32'(C_MEM));
    step();
    drive(5, 0, 1, 5, 1, 1, 1);
    chk("mw_rel_br", 32'(ctrl), 32'(C_DEF));
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("mwbr_cnt", 32'(stall_count), 7);

    // memory stall raised during LOAD_STALL
    drive(5, 0, 1, 5, 0, 0, 1);
    chk("ls_lu", 32'(ctrl), 32'(C_LU));
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("ls_mem", 32'(ctrl), 32'(C_MEM));
    step();
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("ls_rel", 32'(ctrl), 32'(C_DEF));
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("ls_cnt", 32'(stall_count), 9);

    // timeout: 20 frozen cycles, mem_err after the 16th
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("to_frozen", 32'(ctrl), 32'(C_MEM));
      step();
      chk("to_err", 32'(mem_err), (i >= 16) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("to_release", 32'(ctrl), 32'(C_DEF));
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    chk("to_sticky", 32'(mem_err), 1);
    chk("to_cnt", 32'(stall_count), 29);

    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("rst_err_clr", 32'(mem_err), 0);
    chk("rst_cnt_clr", 32'(stall_count), 0);

    // reset in the second MEM_WAIT cycle aborts the stall
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("ra_mw1", 32'(ctrl), 32'(C_MEM));
    step();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("ra_mw2", 32'(ctrl), 32'(C_MEM));
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("ra_run", 32'(ctrl), 32'(C_DEF));
    chk("ra_cnt", 32'(stall_count), 0);
    chk("ra_err", 32'(mem_err), 0);
    step();
    chk("ra_cnt2", 32'(stall_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum consecutive memory-wait cycles before mem_err is asserted.
REQ-002 SHALL have parameter CNT_W, default 16: width of stall_count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 ex_memread  input  1  instruction in EX is a load.
REQ-007 ex_rt  input  5  load destination register in EX.
REQ-008 ex_branch_taken  input  1  branch in EX resolved taken this cycle.
REQ-009 mem_req  input  1  instruction in MEM accesses data memory.
REQ-010 mem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_en, ifid_en, exmem_en  output  1 each  load enables for PC, IF/ID and EX/MEM.
REQ-012 ifid_flush, idex_flush  output  1 each  force a bubble (all-zero control) into IF/ID and ID/EX.
REQ-013 memwb_bubble  output  1  force control_wb = 2'b00 into MEM/WB.
REQ-014 mem_err  output  1  sticky memory-timeout flag.
REQ-015 stall_count  output  CNT_W  saturating count of cycles with pc_en = 0.

Function
REQ-016 The FSM SHALL have states RUN, LOAD_STALL and MEM_WAIT; the control outputs (REQ-011 to REQ-013) SHALL be combinational from state and inputs.
REQ-017 Default outputs: all enables 1; all flush/bubble outputs 0.
REQ-018 Priority SHALL be: memory wait > branch taken > load-use.
REQ-019 Memory stall: in RUN or LOAD_STALL with mem_req=1 and mem_ready=0, SHALL drive pc_en=ifid_en=exmem_en=0 and memwb_bubble=1, and go to MEM_WAIT.
REQ-020 In MEM_WAIT, while mem_ready=0, SHALL hold the REQ-019 outputs and increment the wait counter.
REQ-021 In MEM_WAIT with mem_ready=1, SHALL drive default outputs and return to RUN next cycle; the wait counter SHALL clear.
REQ-022 When the wait counter reaches MEM_TIMEOUT, SHALL set mem_err=1, which then stays 1 until rst; the stall continues.
REQ-023 Branch: ex_branch_taken=1 with no memory stall SHALL drive ifid_flush=idex_flush=1 with pc_en=1 in that cycle, and suppress load-use detection.
REQ-024 Load-use: ex_memread=1, ex_rt!=0, and (ex_rt==id_rs or ex_rt==id_rt), in RUN with no higher-priority event, SHALL drive pc_en=ifid_en=0 and idex_flush=1, and go to LOAD_STALL.
REQ-025 LOAD_STALL SHALL last exactly one cycle with default outputs unless a memory stall occurs, then return to RUN.
REQ-026 A load-use hazard SHALL NOT be re-detected in LOAD_STALL.
REQ-027 stall_count SHALL increment on every cycle with pc_en=0 and saturate at all-ones.
REQ-028 Register $0 (ex_rt=0) SHALL never cause a hazard.

Reset
REQ-029 On rst=1 at a clock edge: state=RUN, wait counter=0, mem_err=0, stall_count=0.
REQ-030 rst during MEM_WAIT or LOAD_STALL SHALL abort the stall; default outputs SHALL apply from the next cycle.

Structure
REQ-031 State encodings and the bubble control value 2'b00 SHALL live in the shared pipeline package pipe_pkg.
REQ-032 Hazard comparison SHALL be a combinational sub-module hazard_detect(ex_memread, ex_rt, id_rs, id_rt -> load_use).

Verification
REQ-033 ex_memread=1, ex_rt=5, id_rs=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle defaults; stall_count=1.
REQ-034 Same as REQ-033 with ex_rt=0 -> no stall.
REQ-035 mem_req=1, mem_ready low for 3 cycles, then high -> 3 frozen cycles with memwb_bubble=1, release on the 4th cycle; stall_count=3.
REQ-036 ex_branch_taken=1 together with the load-use hazard of REQ-033 -> ifid_flush=idex_flush=1, pc_en=1, no LOAD_STALL.
REQ-037 mem_ready held 0 for 20 cycles with MEM_TIMEOUT=16 -> mem_err=1 from cycle 16 on, stays 1 after mem_ready; clears only on rst.
REQ-038 rst asserted in the 2nd MEM_WAIT cycle -> next cycle RUN, default outputs, stall_count=0.
